// File: rtl/edge_pkg.sv
// Shared constants, FSM state type and output clamp for the 5x5 edge-detect convolution engine.
package edge_pkg;

  localparam int KSIZE = 5;
  localparam int NCOEF = 25;
  localparam int ACC_W = 22;
  localparam int PIX_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_COEF,
    LOAD_IMG,
    CONV,
    DONE
  } conv_state_t;

  // Negative sums go to black and anything above full scale goes to white.
  function automatic logic [PIX_W-1:0] sat_u8(input logic signed [ACC_W-1:0] a);
    if (a[ACC_W-1])
      return '0;
    else if (a > $signed(ACC_W'(255)))
      return '1;
    else
      return a[PIX_W-1:0];
  endfunction

endpackage

// File: rtl/edge_conv5x5_frame_ram.sv
// Single-port frame store: synchronous write, one-cycle registered read.
module frame_ram
  import edge_pkg::*;
#(
  parameter int DEPTH = 65536,
  parameter int AW    = 16
) (
  input  logic             clk,
  input  logic             we,
  input  logic             re,
  input  logic [AW-1:0]    addr,
  input  logic [PIX_W-1:0] wdata,
  output logic [PIX_W-1:0] rdata
);

  logic [PIX_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we)
      mem[addr] <= wdata;
    else if (re)
      rdata <= mem[addr];
  end

endmodule

// File: rtl/edge_conv5x5.sv
// Frame-buffered 5x5 convolution: loads 25 coefficients and one frame, then emits one
// clamped result per pixel every 28 cycles with zero padding outside the frame.
module edge_conv5x5
  import edge_pkg::*;
#(
  parameter int IMG_W = 256,
  parameter int IMG_H = 256
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             fc_valid,
  input  logic [7:0]       fc,
  input  logic             pix_valid,
  input  logic [PIX_W-1:0] pix_in,
  output logic             pix_ready,
  output logic [PIX_W-1:0] out_pixel,
  output logic             out_valid,
  output logic             busy,
  output logic             done
);

  localparam int NPIX = IMG_W * IMG_H;
  localparam int AW   = $clog2(NPIX);
  localparam int RW   = $clog2(IMG_H);
  localparam int CW   = $clog2(IMG_W);
  localparam logic signed [RW+1:0] H_S = (RW+2)'(IMG_H);
  localparam logic signed [CW+1:0] W_S = (CW+2)'(IMG_W);

  conv_state_t state, state_nx;

  logic                    start_d;
  logic [4:0]              cnt;
  logic signed [7:0]       coef [NCOEF];
  logic [AW-1:0]           wr_addr;
  logic [4:0]              phase;
  logic [2:0]              m, n;
  logic [RW-1:0]           r;
  logic [CW-1:0]           c;
  logic signed [RW+1:0]    tr;
  logic signed [CW+1:0]    tc;
  logic                    tap_phase, in_frame;
  logic [AW-1:0]           rd_addr, ram_addr;
  logic [PIX_W-1:0]        rdata;
  logic                    tap_vld_d;
  logic [4:0]              tap_k_d;
  logic signed [16:0]      prod;
  logic signed [ACC_W-1:0] acc, acc_sum;
  logic                    last_coef, last_pix, period_end, last_out;

  assign last_coef  = (state == LOAD_COEF) && fc_valid && (cnt == 5'(NCOEF-1));
  assign last_pix   = (state == LOAD_IMG) && pix_valid && (wr_addr == AW'(NPIX-1));
  assign period_end = (state == CONV) && (phase == 5'd27);
  assign last_out   = period_end && (r == RW'(IMG_H-1)) && (c == CW'(IMG_W-1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:      if (start && !start_d) state_nx = LOAD_COEF;
      LOAD_COEF: if (last_coef)         state_nx = LOAD_IMG;
      LOAD_IMG:  if (last_pix)          state_nx = CONV;
      CONV:      if (last_out)          state_nx = DONE;
      DONE:                             state_nx = IDLE;
      default:                          state_nx = IDLE;
    endcase
  end

  always_comb begin
    pix_ready = (state == LOAD_IMG);
    busy      = (state != IDLE);
    done      = (state == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      start_d <= 1'b0;
      cnt     <= '0;
      wr_addr <= '0;
    end else begin
      start_d <= start;
      if (state == IDLE)
        cnt <= '0;
      else if ((state == LOAD_COEF) && fc_valid)
        cnt <= cnt + 5'd1;
      if (state == IDLE)
        wr_addr <= '0;
      else if ((state == LOAD_IMG) && pix_valid)
        wr_addr <= (wr_addr == AW'(NPIX-1)) ? '0 : wr_addr + AW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if ((state == LOAD_COEF) && fc_valid)
      coef[cnt] <= fc;
  end

  // Phase 0..24 walks the 25 taps (m row, n column); 25..27 drain the MAC and emit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase <= '0;
      m     <= '0;
      n     <= '0;
      r     <= '0;
      c     <= '0;
    end else if (state != CONV) begin
      phase <= '0;
      m     <= '0;
      n     <= '0;
      r     <= '0;
      c     <= '0;
    end else begin
      phase <= (phase == 5'd27) ? 5'd0 : phase + 5'd1;
      if (phase < 5'd25) begin
        if (n == 3'd4) begin
          n <= '0;
          m <= m + 3'd1;
        end else begin
          n <= n + 3'd1;
        end
      end else begin
        m <= '0;
        n <= '0;
      end
      if (period_end) begin
        if (c == CW'(IMG_W-1)) begin
          c <= '0;
          r <= (r == RW'(IMG_H-1)) ? '0 : r + RW'(1);
        end else begin
          c <= c + CW'(1);
        end
      end
    end
  end

  always_comb begin
    tap_phase = (state == CONV) && (phase < 5'd25);
    tr        = $signed({2'b00, r}) + $signed({{(RW-1){1'b0}}, m}) - $signed((RW+2)'(2));
    tc        = $signed({2'b00, c}) + $signed({{(CW-1){1'b0}}, n}) - $signed((CW+2)'(2));
    in_frame  = tap_phase && !tr[RW+1] && (tr < H_S) && !tc[CW+1] && (tc < W_S);
    rd_addr   = AW'(tr[RW-1:0]) * AW'(IMG_W) + AW'(tc[CW-1:0]);
    ram_addr  = (state == LOAD_IMG) ? wr_addr : rd_addr;
  end

  frame_ram #(
    .DEPTH (NPIX),
    .AW    (AW)
  ) u_frame_ram (
    .clk   (clk),
    .we    ((state == LOAD_IMG) && pix_valid),
    .re    (in_frame),
    .addr  (ram_addr),
    .wdata (pix_in),
    .rdata (rdata)
  );

  // Pixels are zero-extended so 255 never reads back as -1.
  always_comb begin
    prod    = 17'(coef[tap_k_d]) * 17'($signed({1'b0, rdata}));
    acc_sum = tap_vld_d ? acc + ACC_W'(prod) : acc;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tap_vld_d <= 1'b0;
      tap_k_d   <= '0;
      acc       <= '0;
      out_valid <= 1'b0;
      out_pixel <= '0;
    end else begin
      tap_vld_d <= in_frame;
      tap_k_d   <= phase;
      acc       <= (phase == 5'd0) ? '0 : acc_sum;
      out_valid <= (state == CONV) && (phase == 5'd25);
      if ((state == CONV) && (phase == 5'd25))
        out_pixel <= sat_u8(acc_sum);
    end
  end

endmodule

// File: tb/tb_edge_conv5x5.sv
// Directed bench for edge_conv5x5 on an 8x8 frame with hand-computed expected results.
module tb_edge_conv5x5;

  localparam int W  = 8;
  localparam int H  = 8;
  localparam int NP = W * H;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       fc_valid;
  logic [7:0] fc;
  logic       pix_valid;
  logic [7:0] pix_in;
  logic       pix_ready;
  logic [7:0] out_pixel;
  logic       out_valid;
  logic       busy;
  logic       done;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic signed [7:0] kern  [25];
  logic [7:0]        frame [NP];
  logic [7:0]        outs  [2048];
  int total_out  = 0;
  int total_done = 0;
  int gap_bad    = 0;
  int last_cyc   = 0;
  int run_base   = 0;
  int done_base  = 0;

  edge_conv5x5 #(
    .IMG_W (W),
    .IMG_H (H)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .fc_valid  (fc_valid),
    .fc        (fc),
    .pix_valid (pix_valid),
    .pix_in    (pix_in),
    .pix_ready (pix_ready),
    .out_pixel (out_pixel),
    .out_valid (out_valid),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Captures every result and flags any spacing other than 28 cycles inside a run.
  always @(negedge clk) begin
    if (out_valid) begin
      if (total_out < 2048)
        outs[total_out] <= out_pixel;
      if ((total_out != run_base) && ((cyc - last_cyc) != 28))
        gap_bad <= gap_bad + 1;
      last_cyc  <= cyc;
      total_out <= total_out + 1;
    end
    if (done)
      total_done <= total_done + 1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp_v);
    total++;
    assert (got === exp_v) else begin
      bad++;
      $error("[TB] FAIL %s got=%0d exp=%0d", tag, got, exp_v);
    end
  endtask

  task automatic checkPix(input string tag, input int row, input int col, input int exp_v);
    checkOutput(tag, {24'b0, outs[run_base + row * W + col]}, exp_v);
  endtask

  task automatic applyStimulus(input int gap, input int extra_fc, input bit junk_pix);
    run_base  = total_out;
    done_base = total_done;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 25; k++) begin
      fc_valid  = 1'b1;
      fc        = kern[k];
      pix_valid = junk_pix;
      pix_in    = 8'd77;
      @(negedge clk);
    end
    pix_valid = 1'b0;
    for (int e = 0; e < extra_fc; e++) begin
      fc_valid = 1'b1;
      fc       = 8'd100;
      @(negedge clk);
    end
    fc_valid = 1'b0;
    checkOutput("pix_ready_high", {31'b0, pix_ready}, 1);
    for (int i = 0; i < NP; i++) begin
      pix_valid = 1'b1;
      pix_in    = frame[i];
      @(negedge clk);
      if (gap > 0) begin
        pix_valid = 1'b0;
        repeat (gap) @(negedge clk);
      end
    end
    pix_valid = 1'b0;
    checkOutput("pix_ready_drop", {31'b0, pix_ready}, 0);
  endtask

  task automatic waitDone(input string tag);
    int k = 0;
    while (!done && k < 4000) begin
      @(negedge clk);
      k++;
    end
    checkOutput(tag, {31'b0, done}, 1);
    @(negedge clk);
    #1;
    checkOutput("busy_after_done", {31'b0, busy}, 0);
    checkOutput("done_once", total_done - done_base, 1);
    checkOutput("out_count", total_out - run_base, NP);
  endtask

  task automatic setEdgeKernel();
    for (int k = 0; k < 25; k++) kern[k] = (k == 12) ? 8'sd24 : -8'sd1;
  endtask

  task automatic setIdentityRamp();
    for (int k = 0; k < 25; k++) kern[k] = (k == 12) ? 8'sd1 : 8'sd0;
    for (int i = 0; i < NP; i++) frame[i] = 8'((i / W) + (i % W));
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    fc_valid  = 1'b0;
    fc        = '0;
    pix_valid = 1'b0;
    pix_in    = '0;
    #1;
    checkOutput("rst_pix_ready", {31'b0, pix_ready}, 0);
    checkOutput("rst_out_pixel", {24'b0, out_pixel}, 0);
    checkOutput("rst_out_valid", {31'b0, out_valid}, 0);
    checkOutput("rst_busy", {31'b0, busy}, 0);
    checkOutput("rst_done", {31'b0, done}, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    $display("[TB] run A: edge kernel, flat 100, gapped pixels, 30 coefficient strobes");
    setEdgeKernel();
    for (int i = 0; i < NP; i++) frame[i] = 8'd100;
    applyStimulus(3, 5, 1'b1);
    waitDone("A_done");
    checkPix("A_corner_0_0", 0, 0, 255);
    checkPix("A_edge_0_5", 0, 5, 255);
    checkPix("A_corner_7_7", 7, 7, 255);
    checkPix("A_int_3_3", 3, 3, 0);
    checkPix("A_int_2_5", 2, 5, 0);
    checkPix("A_int_5_2", 5, 2, 0);
    checkOutput("A_spacing", gap_bad, 0);

    $display("[TB] run B: identity kernel, ramp frame");
    setIdentityRamp();
    applyStimulus(0, 0, 1'b0);
    waitDone("B_done");
    for (int i = 0; i < NP; i++)
      checkPix("B_identity", i / W, i % W, (i / W) + (i % W));
    checkOutput("B_spacing", gap_bad, 0);

    $display("[TB] run C: edge kernel, impulse 200 at (4,4)");
    setEdgeKernel();
    for (int i = 0; i < NP; i++) frame[i] = 8'd0;
    frame[4 * W + 4] = 8'd200;
    applyStimulus(0, 0, 1'b0);
    waitDone("C_done");
    checkPix("C_centre", 4, 4, 255);
    checkPix("C_right", 4, 5, 0);
    checkPix("C_diag", 6, 6, 0);
    checkPix("C_far_row", 7, 4, 0);
    checkPix("C_origin", 0, 0, 0);

    $display("[TB] run D: asymmetric kernel, impulses 10 at (4,4) and 200 at (1,0)");
    for (int k = 0; k < 25; k++) kern[k] = 8'(k + 1);
    kern[0] = -8'sd1;
    kern[2] = 8'sd1;
    for (int i = 0; i < NP; i++) frame[i] = 8'd0;
    frame[4 * W + 4] = 8'd10;
    frame[1 * W + 0] = 8'd200;
    applyStimulus(1, 0, 1'b0);
    waitDone("D_done");
    checkPix("D_4_4", 4, 4, 130);
    checkPix("D_2_6", 2, 6, 210);
    checkPix("D_6_2", 6, 2, 50);
    checkPix("D_4_6", 4, 6, 110);
    checkPix("D_5_5", 5, 5, 70);
    checkPix("D_neg_6_6", 6, 6, 0);
    checkPix("D_unsigned_3_0", 3, 0, 200);
    checkPix("D_clamp_0_0", 0, 0, 255);
    checkPix("D_nowrap_0_7", 0, 7, 0);
    checkPix("D_7_0", 7, 0, 0);

    $display("[TB] run E: reset during convolution, then rerun");
    setIdentityRamp();
    applyStimulus(0, 0, 1'b0);
    begin
      int k = 0;
      while (((total_out - run_base) < 10) && k < 4000) begin
        @(negedge clk);
        #1;
        k++;
      end
      checkOutput("E_reached_10", {31'b0, ((total_out - run_base) >= 10)}, 1);
    end
    rst = 1'b1;
    #1;
    checkOutput("E_rst_pix_ready", {31'b0, pix_ready}, 0);
    checkOutput("E_rst_out_pixel", {24'b0, out_pixel}, 0);
    checkOutput("E_rst_out_valid", {31'b0, out_valid}, 0);
    checkOutput("E_rst_busy", {31'b0, busy}, 0);
    checkOutput("E_rst_done", {31'b0, done}, 0);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(0, 0, 1'b0);
    waitDone("E_done");
    for (int i = 0; i < 5; i++)
      checkPix("E_rerun", 0, i, i);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
